// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch front end of the mp4 pipeline. Owns the PC, issues word
// requests on the imem_* magic-memory port, buffers returned instructions in
// a small FIFO and presents the FIFO head to decode with a valid/ready
// handshake. Redirects from execute flush the FIFO, retarget the PC and, if a
// request is still in flight, discard its response when it arrives. Every
// enqueued instruction carries an RVFI order number.
//
// Parameters
//   DEPTH     instruction FIFO entries (power of two, >= 2)
//   RESET_PC  PC loaded on reset
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   imem_address  fetch address (word aligned), held while imem_read=1
//   imem_read     fetch request, held until imem_resp
//   imem_rdata    instruction word, valid with imem_resp
//   imem_resp     one-cycle completion pulse
//   redirect      execute redirects fetch (taken branch / jump)
//   redirect_pc   new PC, bits [1:0] ignored
//   if_valid      FIFO head valid
//   if_ready      decode accepts the head this cycle
//   if_inst       head instruction
//   if_pc         head PC
//   if_pc_next    head predicted next PC (if_pc + 4)
//   if_order      head RVFI order
//
// Optional build macro FETCH_PERF_CTR_EN adds saturating 32-bit counters:
//   perf_fetched  instructions enqueued
//   perf_stall    cycles with imem_read=1 and no imem_resp
//   perf_flush    redirect cycles
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_next,
    output logic [63:0] if_order
`ifdef FETCH_PERF_CTR_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [63:0] order;
    } slot_t;

    logic [1:0]    state_reg,  state_next;
    logic [31:0]   pc_reg,     pc_next;
    logic [31:0]   addr_reg,   addr_next;
    logic [63:0]   order_reg,  order_next;
    logic [CW-1:0] count_reg,  count_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;

    logic  do_pop;
    logic  do_enq;
    logic  do_flush;
    slot_t slot_q [DEPTH];
    slot_t head;

    // Low address bits of a redirect target are forced to zero.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign head         = slot_q[rd_ptr_reg];
    assign if_valid     = (count_reg != '0);
    assign if_inst      = head.inst;
    assign if_pc        = head.pc;
    assign if_pc_next   = head.pc_next;
    assign if_order     = head.order;
    // DISCARD keeps the abandoned request on the bus until memory completes it.
    assign imem_read    = (state_reg != ST_IDLE);
    assign imem_address = addr_reg;

    always_comb begin
        do_pop     = if_valid & if_ready;
        do_enq     = 1'b0;
        do_flush   = 1'b0;
        state_next = state_reg;
        pc_next    = pc_reg;
        order_next = order_reg;

        if (redirect) begin
            do_flush = 1'b1;
            pc_next  = {redirect_pc[31:2], 2'b00};
            // Rewind the order to the oldest flushed instruction; with an empty
            // FIFO nothing wrong-path was numbered, so the order stands.
            if (count_reg != '0) begin
                order_next = head.order;
            end
            case (state_reg)
                // A response landing in the redirect cycle closes the old
                // request, so the new target can be requested right away.
                ST_REQ, ST_DISCARD: state_next = imem_resp ? ST_REQ : ST_DISCARD;
                default:            state_next = ST_REQ;
            endcase
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Free slot judged after this cycle's pop.
                    if ((count_reg - CW'(do_pop)) < DEPTH_C) begin
                        state_next = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (imem_resp) begin
                        do_enq     = 1'b1;
                        pc_next    = pc_reg + 32'd4;
                        order_next = order_reg + 64'd1;
                        state_next = ((count_reg + CW'(1) - CW'(do_pop)) < DEPTH_C)
                                     ? ST_REQ : ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (imem_resp) begin
                        state_next = ((count_reg - CW'(do_pop)) < DEPTH_C)
                                     ? ST_REQ : ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        count_next  = do_flush ? '0 : (count_reg + CW'(do_enq) - CW'(do_pop));
        rd_ptr_next = do_flush ? '0 : (rd_ptr_reg + AW'(do_pop));
        wr_ptr_next = do_flush ? '0 : (wr_ptr_reg + AW'(do_enq));

        // The bus address only moves when a new request is launched; while a
        // request is pending it stays put even if the PC is redirected.
        addr_next = (state_next == ST_REQ) ? pc_next : addr_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= RESET_PC;
            addr_reg   <= RESET_PC;
            order_reg  <= '0;
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            addr_reg   <= addr_next;
            order_reg  <= order_next;
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    // FIFO storage. Slots are cleared on reset so the head outputs read zero
    // out of reset; a flush only moves the pointers.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            slot_t entry_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (do_enq && (wr_ptr_reg == AW'(gi))) begin
                    entry_reg.inst    <= imem_rdata;
                    entry_reg.pc      <= pc_reg;
                    entry_reg.pc_next <= pc_reg + 32'd4;
                    entry_reg.order   <= order_reg;
                end
            end

            assign slot_q[gi] = entry_reg;
        end
    endgenerate

`ifdef FETCH_PERF_CTR_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_flush_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_reg <= '0;
            perf_stall_reg   <= '0;
            perf_flush_reg   <= '0;
        end else begin
            if (do_enq && (perf_fetched_reg != '1)) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if (imem_read && !imem_resp && (perf_stall_reg != '1)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
            if (redirect && (perf_flush_reg != '1)) begin
                perf_flush_reg <= perf_flush_reg + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_stall   = perf_stall_reg;
    assign perf_flush   = perf_flush_reg;
`else
    // Counter-free build: no performance state.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Drives fetch_stage with a magic-memory responder (fixed or random latency)
// and compares the fetch port and FIFO head every cycle against a
// transaction-level reference: a queue of fetched instructions, a next-fetch
// PC, an order counter and a single outstanding-request slot that is either
// live or abandoned by a redirect.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_next;
    logic [63:0] if_order;
`ifdef FETCH_PERF_CTR_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_address (imem_address),
        .imem_read    (imem_read),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_inst      (if_inst),
        .if_pc        (if_pc),
        .if_pc_next   (if_pc_next),
        .if_order     (if_order)
`ifdef FETCH_PERF_CTR_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush)
`endif
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [63:0] order;
    } ent_t;

    // Reference model state
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [63:0] m_order;
    int          m_out;      // 0: nothing outstanding, 1: live request, 2: abandoned request

    ent_t        pop_log[$];
    int          checks = 0;
    int          errors = 0;
    bit          mem_busy;
    int          mem_wait;
    bit          lat_rand;
    int          lat_fixed;
    int          resp_cnt;

    function automatic logic [193:0] exp_vec();
        logic [193:0] v;
        v = '0;
        if (m_out != 0) begin
            v[193]     = 1'b1;
            v[192:161] = m_addr;
        end
        if (m_q.size() > 0) begin
            v[160]     = 1'b1;
            v[159:128] = m_q[0].inst;
            v[127:96]  = m_q[0].pc;
            v[95:64]   = m_q[0].pc + 32'd4;
            v[63:0]    = m_q[0].order;
        end
        return v;
    endfunction

    function automatic logic [193:0] obs_vec();
        logic [193:0] v;
        v = '0;
        v[193] = imem_read;
        if (imem_read !== 1'b0) v[192:161] = imem_address;
        v[160] = if_valid;
        if (if_valid !== 1'b0) begin
            v[159:128] = if_inst;
            v[127:96]  = if_pc;
            v[95:64]   = if_pc_next;
            v[63:0]    = if_order;
        end
        return v;
    endfunction

    task automatic model_step(input bit s_rst, input bit s_ready, input bit s_redir,
                              input logic [31:0] s_rpc, input bit s_resp,
                              input logic [31:0] s_rdata);
        ent_t e;
        bit   pop;
        if (s_rst) begin
            m_q.delete();
            m_pc    = RESET_PC;
            m_addr  = RESET_PC;
            m_order = '0;
            m_out   = 0;
            return;
        end
        pop = s_ready && (m_q.size() > 0);
        if (s_redir) begin
            if (m_q.size() > 0) m_order = m_q[0].order;
            m_q.delete();
            m_pc = {s_rpc[31:2], 2'b00};
            if (m_out != 0) m_out = s_resp ? 0 : 2;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (s_resp && m_out == 1) begin
                e.inst  = s_rdata;
                e.pc    = m_pc;
                e.order = m_order;
                m_q.push_back(e);
                m_pc    = m_pc + 32'd4;
                m_order = m_order + 64'd1;
            end
            if (s_resp) m_out = 0;
        end
        // At most one request in flight, launched only into a free slot.
        if (m_out == 0 && m_q.size() < DEPTH) begin
            m_out  = 1;
            m_addr = m_pc;
        end
    endtask

    // One clock cycle: memory reacts to the current request, inputs are
    // driven, the model advances, then outputs are sampled 1 time unit after
    // the rising edge.
    task automatic tick(input bit t_rst, input bit t_ready, input bit t_redir,
                        input logic [31:0] t_rpc, input bit t_force_resp);
        bit          resp;
        logic [31:0] rdata;
        ent_t        p;
        resp  = 1'b0;
        rdata = $urandom;
        if (t_force_resp) begin
            resp = 1'b1;
        end else if (!t_rst && imem_read === 1'b1) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
            end
            if (mem_wait == 0) begin
                resp     = 1'b1;
                mem_busy = 1'b0;
                resp_cnt++;
            end else begin
                mem_wait--;
            end
        end
        if (t_rst) mem_busy = 1'b0;
        if (!t_rst && !t_redir && t_ready && if_valid === 1'b1) begin
            p.inst  = if_inst;
            p.pc    = if_pc;
            p.order = if_order;
            pop_log.push_back(p);
        end
        rst         = t_rst;
        if_ready    = t_ready;
        redirect    = t_redir;
        redirect_pc = t_rpc;
        imem_resp   = resp;
        imem_rdata  = rdata;
        model_step(t_rst, t_ready, t_redir, t_rpc, resp, rdata);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        pop_log.delete();
        resp_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (imem_read !== 1'b0) begin
            errors++; $display("FAIL reset_read got=%b exp=0", imem_read);
        end
        checks++;
        if (imem_address !== RESET_PC) begin
            errors++; $display("FAIL reset_addr got=%h exp=%h", imem_address, RESET_PC);
        end
        checks++;
        if (if_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%b exp=0", if_valid);
        end
        checks++;
        if ({if_inst, if_pc, if_pc_next} !== 96'd0) begin
            errors++; $display("FAIL reset_head got=%h/%h/%h exp=0", if_inst, if_pc, if_pc_next);
        end
        checks++;
        if (if_order !== 64'd0) begin
            errors++; $display("FAIL reset_order got=%h exp=0", if_order);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] ep;
        lat_rand = 1'b0; lat_fixed = 1;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL seq cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 3; i++) begin
            ep = RESET_PC + 32'(4 * i);
            checks++;
            if (i >= pop_log.size()) begin
                errors++; $display("FAIL seq_pop%0d got=none exp=pc %h", i, ep);
            end else if (pop_log[i].pc !== ep || pop_log[i].order !== 64'(i)) begin
                errors++; $display("FAIL seq_pop%0d got=pc %h ord %0d exp=pc %h ord %0d",
                                   i, pop_log[i].pc, pop_log[i].order, ep, i);
            end
        end
    endtask

    task automatic test_backpressure();
        lat_rand = 1'b0; lat_fixed = 1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL bp cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (imem_read !== 1'b0 || resp_cnt != DEPTH) begin
            errors++; $display("FAIL bp_full got=read %b fetched %0d exp=read 0 fetched %0d",
                               imem_read, resp_cnt, DEPTH);
        end
        tick(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        checks++;
        if (imem_read !== 1'b1 || if_valid !== 1'b1) begin
            errors++; $display("FAIL bp_pop got=read %b valid %b exp=read 1 valid 1", imem_read, if_valid);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL bp2 cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_redirect_wait();
        bit found;
        lat_rand = 1'b0; lat_fixed = 4;
        do_reset();
        for (int i = 0; i < 5 && imem_read !== 1'b1; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 32'h4000_0103, 1'b0);
        checks++;
        if (imem_read !== 1'b1 || imem_address !== RESET_PC || if_valid !== 1'b0) begin
            errors++; $display("FAIL rdw_hold got=read %b addr %h valid %b exp=read 1 addr %h valid 0",
                               imem_read, imem_address, if_valid, RESET_PC);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rdw cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (imem_read === 1'b1 && imem_address === 32'h4000_0100) found = 1'b1;
        end
        checks++;
        if (!found || if_valid !== 1'b0) begin
            errors++; $display("FAIL rdw_target got=found %b valid %b exp=found 1 valid 0", found, if_valid);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rdw2 cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_redirect_resp();
        bit hit;
        lat_rand = 1'b0; lat_fixed = 1;
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
            if (if_valid === 1'b1 && imem_read === 1'b1 && mem_busy && mem_wait == 0) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL rdr_setup got=no pending response exp=pending response");
        end else begin
            tick(1'b0, 1'b0, 1'b1, 32'h4000_0200, 1'b0);
            checks++;
            if (if_valid !== 1'b0 || imem_read !== 1'b1 || imem_address !== 32'h4000_0200) begin
                errors++; $display("FAIL rdr_flush got=valid %b read %b addr %h exp=valid 0 read 1 addr 40000200",
                                   if_valid, imem_read, imem_address);
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rdr cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        lat_rand = 1'b0; lat_fixed = 3;
        do_reset();
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 10 && !(imem_read === 1'b1 && mem_busy); i++)
            tick(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        checks++;
        if (imem_read !== 1'b0 || if_valid !== 1'b0 || if_order !== 64'd0) begin
            errors++; $display("FAIL rstmid got=read %b valid %b order %0d exp=0 0 0",
                               imem_read, if_valid, if_order);
        end
        pop_log.delete();
        tick(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        checks++;
        if (imem_read !== 1'b1 || imem_address !== RESET_PC || if_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_restart got=read %b addr %h valid %b exp=read 1 addr %h valid 0",
                               imem_read, imem_address, if_valid, RESET_PC);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rstmid cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (pop_log.size() == 0 || pop_log[0].pc !== RESET_PC || pop_log[0].order !== 64'd0) begin
            errors++; $display("FAIL rstmid_first got=%0d pops exp=pc %h order 0", pop_log.size(), RESET_PC);
        end
    endtask

    task automatic test_random();
        bit          rdy;
        bit          rdr;
        logic [31:0] rpc;
        lat_rand = 1'b1;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rdr = ($urandom_range(0, 11) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            tick(1'b0, rdy, rdr, rpc, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rand cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

`ifdef FETCH_PERF_CTR_EN
    task automatic test_perf();
        lat_rand = 1'b0; lat_fixed = 1;
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (imem_read !== 1'b0) begin
            errors++; $display("FAIL perf_idle got=read %b exp=0", imem_read);
        end
        tick(1'b0, 1'b0, 1'b1, 32'h4000_0300, 1'b0);
        checks++;
        if (perf_fetched !== 32'd3 || perf_stall !== 32'd3 || perf_flush !== 32'd1) begin
            errors++; $display("FAIL perf got=%0d/%0d/%0d exp=3/3/1", perf_fetched, perf_stall, perf_flush);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; if_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_resp = 1'b0; imem_rdata = '0;
        mem_busy = 1'b0; mem_wait = 0; lat_rand = 1'b0; lat_fixed = 1; resp_cnt = 0;
        m_pc = RESET_PC; m_addr = RESET_PC; m_order = '0; m_out = 0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_resp();
        test_reset_mid();
        test_random();
`ifdef FETCH_PERF_CTR_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
